// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with a one-word holding
// buffer so that consecutive frames leave the serial line with no idle bits.
//
// Parameters
//   WIDTH      parallel word width (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  a word is offered on din
//   din         parallel word
//   load_ready  a word can be taken this cycle
//   shift_en    bit-rate strobe: the bit on sout is consumed on this edge
//   sout        serial data bit (0 when idle)
//   sout_valid  sout carries a frame bit
//   busy        a frame is in progress
//   done        one-cycle pulse after the last bit of every frame
//   dbg_state   FSM state (0 = IDLE, 1 = SHIFT) for observation
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both 1. load_ready depends only on the holding-buffer flag
// (and rst), never on load_valid, so the producer may wait on it freely.
// Once load_valid is raised the producer holds din stable until the transfer.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             hold_full_q, hold_full_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             busy_q, done_q, done_n;
  logic             load_acc;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  assign load_ready = ~hold_full_q & ~rst;
  assign load_acc   = load_valid & load_ready;
  assign last_bit   = shift_en & (cnt_q == LAST);

  // Shift toward the output end with zero fill.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  // The shift register is cleared on the way back to IDLE, so its output-end
  // bit is already 0 whenever no frame is active.
  assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = (state_q == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      shreg_q     <= shreg_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      cnt_q       <= cnt_n;
      busy_q      <= (state_n == SHIFT);
      done_q      <= done_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    shreg_n     = shreg_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    cnt_n       = cnt_q;
    done_n      = 1'b0;

    case (state_q)
      IDLE: begin
        // shift_en is meaningless without a frame and is ignored here.
        if (load_acc) begin
          shreg_n = din;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (last_bit) begin
          done_n = 1'b1;
          cnt_n  = '0;
          if (hold_full_q) begin
            // Queued word follows immediately; load_ready was 0 so no
            // new word can arrive on this edge.
            shreg_n     = hold_q;
            hold_full_n = 1'b0;
          end else if (load_acc) begin
            // Word arriving on the last edge bypasses the holding buffer.
            shreg_n = din;
          end else begin
            shreg_n = '0;
            state_n = IDLE;
          end
        end else begin
          if (shift_en) begin
            shreg_n = shifted;
            cnt_n   = cnt_q + CW'(1);
          end
          if (load_acc) begin
            hold_n      = din;
            hold_full_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] din = 4'b0000;
  logic       shift_en = 1'b0;
  logic       load_ready, sout, sout_valid, busy, done, dbg_state;

  logic       l_load_valid = 1'b0;
  logic [3:0] l_din = 4'b0000;
  logic       l_shift_en = 1'b0;
  logic       l_load_ready, l_sout, l_sout_valid, l_busy, l_done, l_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference 4-bit SIPO fed from the serial line on consumed bits.
  logic [3:0] sipo = 4'b0000;
  logic       sipo_clr = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sipo_clr) sipo <= 4'b0000;
    else if (shift_en && sout_valid) sipo <= {sipo[2:0], sout};
  end

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .din(din),
    .load_ready(load_ready), .shift_en(shift_en), .sout(sout),
    .sout_valid(sout_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(l_load_valid), .din(l_din),
    .load_ready(l_load_ready), .shift_en(l_shift_en), .sout(l_sout),
    .sout_valid(l_sout_valid), .busy(l_busy), .done(l_done), .dbg_state(l_dbg_state)
  );

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; din = 4'b1111; shift_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sout, sout_valid, busy, done, load_ready, dbg_state} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {sout, sout_valid, busy, done, load_ready, dbg_state});
    end
    rst = 1'b0; load_valid = 1'b0; shift_en = 1'b0;
    #1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", load_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, sout_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_no_load: busy,valid got %b expected 00", {busy, sout_valid});
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] w;
    w = 4'b1010;
    din = w; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({sout, sout_valid, busy, done} !== {w[3-i], 3'b110}) begin
        n_err++;
        $display("FAIL single_bit%0d: sout,valid,busy,done got %b expected %b",
                 i, {sout, sout_valid, busy, done}, {w[3-i], 3'b110});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, sout_valid, sout} !== 4'b1000) begin
      n_err++; $display("FAIL single_done: done,busy,valid,sout got %b expected 1000",
                        {done, busy, sout_valid, sout});
    end
    shift_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL single_after: done,busy got %b expected 00", {done, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    int         n_done;
    exp_bits = 8'b1010_0110;
    n_done = 0;
    din = 4'b1010; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (done) n_done++;
      n_cmp++;
      if ({sout, sout_valid} !== {exp_bits[7-i], 1'b1}) begin
        n_err++; $display("FAIL b2b_bit%0d: sout,valid got %b expected %b",
                          i, {sout, sout_valid}, {exp_bits[7-i], 1'b1});
      end
      if (i == 0) begin
        din = 4'b0110; load_valid = 1'b1;
      end else if (i == 1) begin
        load_valid = 1'b0; din = 4'b1111;
      end
      if (i >= 2 && i <= 3) begin
        n_cmp++;
        if (load_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_ready_full%0d: got %b expected 0", i, load_ready);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (load_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_ready_free: got %b expected 1", load_ready);
        end
      end
    end
    @(negedge clk);
    if (done) n_done++;
    shift_en = 1'b0;
    n_cmp++;
    if (n_done != 2 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: pulses got %0d busy %b expected 2 pulses busy 0", n_done, busy);
    end
  endtask

  task automatic test_throttled();
    logic [3:0] w;
    int         n_done;
    w = 4'b1100;
    n_done = 0;
    din = w; load_valid = 1'b1; shift_en = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (done) n_done++;
      n_cmp++;
      if ({sout, sout_valid} !== {w[3-(c-1)/3], 1'b1}) begin
        n_err++; $display("FAIL thr_cycle%0d: sout,valid got %b expected %b",
                          c, {sout, sout_valid}, {w[3-(c-1)/3], 1'b1});
      end
      shift_en = (c % 3 == 0);
    end
    @(negedge clk);
    shift_en = 1'b0;
    if (done) n_done++;
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL thr_end: done,busy got %b expected 10", {done, busy});
    end
    @(negedge clk);
    if (done) n_done++;
    n_cmp++;
    if (n_done != 1) begin
      n_err++; $display("FAIL thr_done_count: got %0d expected 1", n_done);
    end
  endtask

  task automatic test_abort();
    logic [3:0] w;
    w = 4'b0011;
    din = 4'b1111; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    din = 4'b0101;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sout_valid, busy, sout, done, load_ready} !== 5'b00000) begin
      n_err++; $display("FAIL abort_immediate: valid,busy,sout,done,ready got %b expected 00000",
                        {sout_valid, busy, sout, done, load_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    din = w; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done: got %b expected 0", done);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({sout, sout_valid} !== {w[3-i], 1'b1}) begin
        n_err++; $display("FAIL abort_fresh_bit%0d: sout,valid got %b expected %b",
                          i, {sout, sout_valid}, {w[3-i], 1'b1});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL abort_fresh_done: done,busy got %b expected 10", {done, busy});
    end
    @(negedge clk);
    shift_en = 1'b0;
    n_cmp++;
    if ({sout_valid, busy, sout} !== 3'b000) begin
      n_err++; $display("FAIL abort_queue_dropped: valid,busy,sout got %b expected 000",
                        {sout_valid, busy, sout});
    end
  endtask

  task automatic test_loopback();
    sipo_clr = 1'b1;
    @(negedge clk);
    sipo_clr = 1'b0;
    din = 4'b1010; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    shift_en = 1'b0;
    n_cmp++;
    if (sipo !== 4'b1010) begin
      n_err++; $display("FAIL loopback_sipo: got %b expected 1010", sipo);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_seq;
    exp_seq = 4'b0101;  // bits in transmit order, first at [3]
    l_din = 4'b1010; l_load_valid = 1'b1; l_shift_en = 1'b1;
    @(negedge clk);
    l_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({l_sout, l_sout_valid} !== {exp_seq[3-i], 1'b1}) begin
        n_err++; $display("FAIL lsb_bit%0d: sout,valid got %b expected %b",
                          i, {l_sout, l_sout_valid}, {exp_seq[3-i], 1'b1});
      end
    end
    @(negedge clk);
    l_shift_en = 1'b0;
    n_cmp++;
    if ({l_done, l_busy} !== 2'b10) begin
      n_err++; $display("FAIL lsb_done: done,busy got %b expected 10", {l_done, l_busy});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_throttled();
    test_abort();
    test_loopback();
    test_lsb_first();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
